// File: rtl/ram_write_arbiter_4core.sv
// Round-robin write arbiter driving the single write port of the shared 4-core RAM.
// Define RAM_ARB_HOLD_EN to let a locking owner keep the port for up to MAX_HOLD writes.
module ram_write_arbiter_4core #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req0,
  input  logic              wr_req1,
  input  logic              wr_req2,
  input  logic              wr_req3,
  input  logic              wr_lock0,
  input  logic              wr_lock1,
  input  logic              wr_lock2,
  input  logic              wr_lock3,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [ADDR_W-1:0] wr_addr3,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  input  logic [DATA_W-1:0] wr_data3,
  output logic              wr_ack0,
  output logic              wr_ack1,
  output logic              wr_ack2,
  output logic              wr_ack3,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [1:0]        grant_id_q, grant_id_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [3:0]        ack_q, ack_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [3:0]        req_vec;
  logic [3:0]        lock_vec;
  logic              rr_found;
  logic [1:0]        rr_winner;
  logic [1:0]        rr_idx;
  logic [1:0]        sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              hold_ok;

  assign req_vec  = {wr_req3, wr_req2, wr_req1, wr_req0};
  assign lock_vec = {wr_lock3, wr_lock2, wr_lock1, wr_lock0};

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_grant_q;
    rr_idx    = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_grant_q + 2'(i);
      if (!rr_found && req_vec[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_comb begin
    sel_addr = wr_addr0;
    sel_data = wr_data0;
    case (sel_id)
      2'd0: begin sel_addr = wr_addr0; sel_data = wr_data0; end
      2'd1: begin sel_addr = wr_addr1; sel_data = wr_data1; end
      2'd2: begin sel_addr = wr_addr2; sel_data = wr_data2; end
      default: begin sel_addr = wr_addr3; sel_data = wr_data3; end
    endcase
  end

`ifdef RAM_ARB_HOLD_EN
  assign hold_ok = lock_vec[grant_id_q] && (hold_cnt_q < 4'(MAX_HOLD));
`else
  logic unused_hold;
  assign hold_ok     = 1'b0;
  assign unused_hold = ^{lock_vec, hold_cnt_q, 4'(MAX_HOLD)};
`endif

  // hold_cnt counts writes in the current ownership streak, including the first one.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    hold_cnt_d   = hold_cnt_q;
    ack_d        = 4'b0000;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sel_id       = grant_id_q;
    case (state_q)
      IDLE: begin
        hold_cnt_d = 4'd0;
        sel_id     = rr_winner;
        if (rr_found) begin
          state_d           = WRITE;
          last_grant_d      = rr_winner;
          grant_id_d        = rr_winner;
          hold_cnt_d        = 4'd1;
          ack_d[rr_winner]  = 1'b1;
          mem_we_d          = 1'b1;
          mem_addr_d        = sel_addr;
          mem_wdata_d       = sel_data;
        end
      end
      WRITE: begin
        state_d = hold_ok ? HOLD : IDLE;
      end
      HOLD: begin
        if (req_vec[grant_id_q] && lock_vec[grant_id_q]) begin
          state_d           = WRITE;
          hold_cnt_d        = hold_cnt_q + 4'd1;
          ack_d[grant_id_q] = 1'b1;
          mem_we_d          = 1'b1;
          mem_addr_d        = sel_addr;
          mem_wdata_d       = sel_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      grant_id_q   <= 2'd0;
      hold_cnt_q   <= 4'd0;
      ack_q        <= 4'b0000;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      hold_cnt_q   <= hold_cnt_d;
      ack_q        <= ack_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign wr_ack0   = ack_q[0];
  assign wr_ack1   = ack_q[1];
  assign wr_ack2   = ack_q[2];
  assign wr_ack3   = ack_q[3];
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_write_arbiter_4core.sv
// Self-checking bench for ram_write_arbiter_4core: cycle model plus directed scenarios.
// Hold-mode expectations are selected by RAM_ARB_HOLD_EN.
module tb_ram_write_arbiter_4core;

  localparam int MAX_HOLD = 4;
`ifdef RAM_ARB_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  lock = 4'b0000;
  logic [15:0] addr [4];
  logic [15:0] data [4];
  logic [3:0]  ackOut;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic [1:0]  grantId;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pend [4];
  int cycleCount = 0;
  int ackLog [$];
  int ackCyc [$];
  logic [15:0] ram [int];
  bit checkEn = 1'b0;

  // Model: expected registered outputs plus abstract arbitration bookkeeping.
  logic        expWe;
  logic [3:0]  expAck;
  logic [15:0] expAddr;
  logic [15:0] expData;
  logic [1:0]  expGid;
  logic        expBusy;
  int          mPhase;
  int          mLast;
  int          mStreak;

  ram_write_arbiter_4core #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .wr_req0(req[0]), .wr_req1(req[1]), .wr_req2(req[2]), .wr_req3(req[3]),
    .wr_lock0(lock[0]), .wr_lock1(lock[1]), .wr_lock2(lock[2]), .wr_lock3(lock[3]),
    .wr_addr0(addr[0]), .wr_addr1(addr[1]), .wr_addr2(addr[2]), .wr_addr3(addr[3]),
    .wr_data0(data[0]), .wr_data1(data[1]), .wr_data2(data[2]), .wr_data3(data[3]),
    .wr_ack0(ackOut[0]), .wr_ack1(ackOut[1]), .wr_ack2(ackOut[2]), .wr_ack3(ackOut[3]),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .grant_id(grantId), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model steps on each edge: a write slot is granted from an idle slot by round-robin,
  // lasts one cycle, and a locking owner may continue its streak after a gap cycle.
  always @(posedge clk) begin
    if (reset) begin
      expWe = 0; expAck = 0; expAddr = 0; expData = 0; expGid = 0; expBusy = 0;
      mPhase = 0; mLast = 3; mStreak = 0;
      checkEn = 1'b1;
    end else begin
      expWe = 0;
      expAck = 0;
      if (mPhase == 0) begin
        mStreak = 0;
        expBusy = 0;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (mLast + k) % 4;
          if (req[c] && !expWe) begin
            expWe = 1; expAck[c] = 1; expAddr = addr[c]; expData = data[c];
            expGid = 2'(c); mLast = c; mStreak = 1; mPhase = 1; expBusy = 1;
          end
        end
      end else if (mPhase == 1) begin
        if (HOLD_EN && lock[expGid] && mStreak < MAX_HOLD) begin
          mPhase = 2; expBusy = 1;
        end else begin
          mPhase = 0; expBusy = 0;
        end
      end else begin
        if (req[expGid] && lock[expGid]) begin
          expWe = 1; expAck[expGid] = 1; expAddr = addr[expGid]; expData = data[expGid];
          mStreak++; mPhase = 1; expBusy = 1;
        end else begin
          mPhase = 0; expBusy = 0;
        end
      end
    end
  end

  // Every cycle after the first reset edge the DUT must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("mem_we", 32'(memWe), 32'(expWe));
      checkOutput("wr_ack", 32'(ackOut), 32'(expAck));
      checkOutput("grant_id", 32'(grantId), 32'(expGid));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("mem_addr", 32'(memAddr), 32'(expAddr));
      checkOutput("mem_wdata", 32'(memWdata), 32'(expData));
      checkOutput("ack_onehot", 32'($countones(ackOut)), 32'(memWe ? 1 : 0));
    end
  end

  // Advance one cycle as the cores: consume acks, move to the next write, update requests.
  task automatic stepCycle();
    @(negedge clk);
    cycleCount++;
    if (!reset && memWe) ram[int'(memAddr)] = memWdata;
    for (int i = 0; i < 4; i++) begin
      if (!reset && ackOut[i]) begin
        ackLog.push_back(i);
        ackCyc.push_back(cycleCount);
        if (pend[i] > 0) pend[i]--;
        addr[i] = addr[i] + 16'h0001;
        data[i] = data[i] + 16'h0101;
      end
      req[i] = (pend[i] > 0);
    end
  endtask

  task automatic applyStimulus(input int c, input int n, input logic [15:0] a, input logic [15:0] d, input bit lk);
    pend[c] = n;
    addr[c] = a;
    data[c] = d;
    lock[c] = lk;
    req[c]  = (n > 0);
  endtask

  task automatic clearLogs();
    ackLog.delete();
    ackCyc.delete();
    ram.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i, 0, 16'h0000, 16'h0000, 1'b0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    clearLogs();
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((pend[0] + pend[1] + pend[2] + pend[3] > 0 || busy || memWe) && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic checkSeq(input string name, input int expSeq [$]);
    checkOutput({name, "_len"}, 32'(ackLog.size() >= expSeq.size()), 32'd1);
    for (int k = 0; k < expSeq.size(); k++)
      if (k < ackLog.size()) checkOutput($sformatf("%s[%0d]", name, k), 32'(ackLog[k]), 32'(expSeq[k]));
  endtask

  initial begin
    int seqA [$];
    for (int i = 0; i < 4; i++) begin pend[i] = 0; addr[i] = 0; data[i] = 0; end

    // Reset state and a single request from core 2.
    doReset();
    checkOutput("rst_we", 32'(memWe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gid", 32'(grantId), 32'd0);
    applyStimulus(2, 1, 16'h0010, 16'hBEEF, 1'b0);
    stepCycle();
    checkOutput("single_we", 32'(memWe), 32'd1);
    checkOutput("single_addr", 32'(memAddr), 32'h0010);
    checkOutput("single_data", 32'(memWdata), 32'hBEEF);
    checkOutput("single_ack", 32'(ackOut), 32'b0100);
    checkOutput("single_gid", 32'(grantId), 32'd2);
    stepCycle();
    checkOutput("single_we_off", 32'(memWe), 32'd0);

    // All four requesting continuously.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 2, 16'(16'h0100 * i), 16'(16'h1000 * i), 1'b0);
    waitDone("rr");
    seqA = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkSeq("rr_order", seqA);
    for (int k = 0; k + 1 < ackCyc.size(); k++)
      checkOutput($sformatf("rr_gap%0d", k), 32'(ackCyc[k+1] - ackCyc[k]), 32'd2);

    // Same-address collision: core 1 first, core 3 last writer.
    doReset();
    applyStimulus(1, 1, 16'h0005, 16'hAAAA, 1'b0);
    applyStimulus(3, 1, 16'h0005, 16'h5555, 1'b0);
    waitDone("coll");
    seqA = '{1, 3};
    checkSeq("coll_order", seqA);
    checkOutput("coll_ram", 32'(ram.exists(5) ? ram[5] : 16'h0000), 32'h5555);

    // Reset while WRITE is in flight; round-robin pointer must return to core 0 priority.
    doReset();
    applyStimulus(2, 1, 16'h0020, 16'h1234, 1'b0);
    stepCycle();
    checkOutput("rw_in_write", 32'(memWe), 32'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("rw_we", 32'(memWe), 32'd0);
    checkOutput("rw_ack", 32'(ackOut), 32'd0);
    checkOutput("rw_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    clearLogs();
    applyStimulus(0, 1, 16'h0030, 16'h0A0A, 1'b0);
    applyStimulus(3, 1, 16'h0033, 16'h3B3B, 1'b0);
    waitDone("rw");
    seqA = '{0, 3};
    checkSeq("rw_order", seqA);

    // Locking owner versus a competing core.
    doReset();
    applyStimulus(0, 6, 16'h0200, 16'hC000, 1'b1);
    applyStimulus(1, 3, 16'h0300, 16'hD000, 1'b0);
    waitDone("hold");
    if (HOLD_EN) seqA = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    else         seqA = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
    checkSeq("hold_order", seqA);

    stepCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
